// File: rtl/fetch_req_sequencer_pkg.sv
// Shared fetch pipeline definitions: FSM state enum, buffer entry struct, buffer depth.
// Buffer depth is 2 when FETCH_SKID_BUF_EN is defined, otherwise 1.
`ifndef XLEN
`define XLEN 32
`endif

package fetch_req_sequencer_pkg;

  localparam int unsigned XLEN = `XLEN;

`ifdef FETCH_SKID_BUF_EN
  localparam int unsigned FETCH_BUF_DEPTH = 2;
`else
  localparam int unsigned FETCH_BUF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    KILL  = 2'd2,
    FAULT = 2'd3
  } type_fetch_seq_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } type_fetch_buf_entry_s;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO between the fetch sequencer and decode; flush overrides push and pop.
module fetch_buf
  import fetch_req_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop_req,
  input  logic                  flush,
  input  type_fetch_buf_entry_s push_data,
  output type_fetch_buf_entry_s head,
  output logic                  valid,
  output logic                  space,
  output logic                  space_after_push
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  type_fetch_buf_entry_s mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    valid            = (count_q != '0);
    space            = (count_q != CW'(DEPTH));
    // Space check excludes any same-cycle pop so the sequencer never relies on it.
    space_after_push = ((int'(count_q) + 1) < int'(DEPTH));
    do_push          = push & ~flush & space;
    do_pop           = pop_req & valid & ~flush;
    rd_ptr_d         = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d         = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d          = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    head = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_req_sequencer.sv
// Instruction fetch request sequencer: PC register, I-cache handshake FSM, decode buffer.
// Buffer depth controlled by FETCH_SKID_BUF_EN (see fetch_req_sequencer_pkg).
module fetch_req_sequencer
  import fetch_req_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redirect_req,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req,
  output logic [XLEN-1:0] icache_addr,
  output logic            icache_kill,
  input  logic            icache_ack,
  input  logic [31:0]     icache_instr,
  input  logic            icache_fault,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault,
  input  logic            id_ready,
  output logic            busy
);

  type_fetch_seq_state_e state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  req_q, req_d;
  logic                  kill_q, kill_d;
  logic                  busy_q, busy_d;
  logic                  push, flush, space, space_after_push;
  type_fetch_buf_entry_s push_data, head;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    kill_d    = 1'b0;
    push_data = '{instr: icache_instr, pc: pc_q, fault: icache_fault};
    case (state_q)
      IDLE: begin
        if (redirect_req) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (fetch_en && space) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_req) begin
          // A same-cycle ack retires the request, so nothing is left to kill.
          pc_d    = redirect_pc;
          flush   = 1'b1;
          kill_d  = ~icache_ack;
          state_d = icache_ack ? IDLE : KILL;
        end else if (icache_ack) begin
          push = 1'b1;
          if (icache_fault) begin
            state_d = FAULT;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = (fetch_en && space_after_push) ? REQ : IDLE;
          end
        end
      end
      KILL: begin
        if (redirect_req) pc_d = redirect_pc;
        if (icache_ack)   state_d = IDLE;
      end
      FAULT: begin
        if (redirect_req) begin
          pc_d    = redirect_pc;
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      kill_q  <= kill_d;
      busy_q  <= busy_d;
    end
  end

  fetch_buf #(.DEPTH(FETCH_BUF_DEPTH)) u_fetch_buf (
    .clk              (clk),
    .rst              (rst),
    .push             (push),
    .pop_req          (id_ready),
    .flush            (flush),
    .push_data        (push_data),
    .head             (head),
    .valid            (id_valid),
    .space            (space),
    .space_after_push (space_after_push)
  );

  assign icache_req  = req_q;
  assign icache_addr = pc_q;
  assign icache_kill = kill_q;
  assign busy        = busy_q;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_fault    = head.fault;

endmodule

// File: tb/tb_fetch_req_sequencer.sv
// Directed bench for fetch_req_sequencer; expectations adapt to the buffer depth macro.
module tb_fetch_req_sequencer;

`ifdef FETCH_SKID_BUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_req, icache_ack, icache_fault, id_ready;
  logic [31:0] redirect_pc, icache_instr;
  logic        icache_req, icache_kill, id_valid, id_fault, busy;
  logic [31:0] icache_addr, id_instr, id_pc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fetch_req_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_kill  (icache_kill),
    .icache_ack   (icache_ack),
    .icache_instr (icache_instr),
    .icache_fault (icache_fault),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_fault     (id_fault),
    .id_ready     (id_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int unsigned n = 0;
    while (icache_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, {31'd0, icache_req}, 32'd1);
    check({tag, "_addr"}, icache_addr, exp_addr);
  endtask

  task automatic ack_once(input logic [31:0] instr, input logic fault);
    icache_ack   = 1'b1;
    icache_instr = instr;
    icache_fault = fault;
    step();
    icache_ack   = 1'b0;
    icache_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_req = 1'b0; redirect_pc = '0;
    icache_ack = 1'b0; icache_instr = '0; icache_fault = 1'b0; id_ready = 1'b0;
    step(); step();
    check("rst_req",   {31'd0, icache_req},  32'd0);
    check("rst_kill",  {31'd0, icache_kill}, 32'd0);
    check("rst_valid", {31'd0, id_valid},    32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_addr",  icache_addr,          32'h0);

    // Sequential fetch with decode always ready.
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req("seq", 32'(i * 4));
      ack_once(32'hA000_0000 | 32'(i * 4), 1'b0);
      check("seq_valid", {31'd0, id_valid}, 32'd1);
      check("seq_pc",    id_pc,             32'(i * 4));
      check("seq_instr", id_instr,          32'hA000_0000 | 32'(i * 4));
      check("seq_fault", {31'd0, id_fault}, 32'd0);
    end
    step();

    // Decode stalled: buffer fills, then drains in order.
    id_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wait_req("fill", 32'h0C + 32'(i * 4));
      ack_once(32'hB000_0000 | 32'(i), 1'b0);
    end
    check("full_req",  {31'd0, icache_req}, 32'd0);
    check("full_busy", {31'd0, busy},       32'd0);
    step(); step(); step();
    check("full_req_hold", {31'd0, icache_req}, 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("drain_valid", {31'd0, id_valid}, 32'd1);
      check("drain_pc",    id_pc,             32'h0C + 32'(i * 4));
      step();
    end
    check("drained_valid", {31'd0, id_valid}, 32'd0);
    wait_req("resume", 32'h0C + 32'(DEPTH * 4));

    // Redirect without ack: kill pulse, late ack dropped.
    redirect_req = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_req = 1'b0;
    check("kill_pulse", {31'd0, icache_kill}, 32'd1);
    check("kill_req",   {31'd0, icache_req},  32'd0);
    check("kill_busy",  {31'd0, busy},        32'd1);
    check("kill_addr",  icache_addr,          32'h8000_0100);
    step();
    check("kill_one_cycle", {31'd0, icache_kill}, 32'd0);
    check("kill_hold_req",  {31'd0, icache_req},  32'd0);
    ack_once(32'hDEAD_BEEF, 1'b0);
    check("late_ack_drop", {31'd0, id_valid}, 32'd0);
    check("late_ack_idle", {31'd0, busy},     32'd0);
    wait_req("post_kill", 32'h8000_0100);

    // Redirect coincident with ack: no push, no kill.
    redirect_req = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    ack_once(32'h1111_1111, 1'b0);
    redirect_req = 1'b0;
    check("rdack_kill",  {31'd0, icache_kill}, 32'd0);
    check("rdack_valid", {31'd0, id_valid},    32'd0);
    check("rdack_busy",  {31'd0, busy},        32'd0);
    wait_req("rdack", 32'hFFFF_FFFC);

    // PC wrap at the top of the address space.
    ack_once(32'h2222_2222, 1'b0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    wait_req("wrap", 32'h0000_0000);

    // Fault: entry flagged, fetch halts until redirect.
    redirect_req = 1'b1; redirect_pc = 32'h40;
    ack_once(32'h3333_3333, 1'b0);
    redirect_req = 1'b0;
    wait_req("pre_fault", 32'h40);
    ack_once(32'h4444_4444, 1'b1);
    check("fault_valid", {31'd0, id_valid}, 32'd1);
    check("fault_pc",    id_pc,             32'h40);
    check("fault_flag",  {31'd0, id_fault}, 32'd1);
    check("fault_req",   {31'd0, icache_req}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("fault_stall_req",  {31'd0, icache_req}, 32'd0);
    check("fault_stall_busy", {31'd0, busy},       32'd1);
    redirect_req = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_req = 1'b0;
    check("fault_exit_busy", {31'd0, busy}, 32'd0);
    check("fault_exit_addr", icache_addr,   32'h100);
    wait_req("post_fault", 32'h100);

    // Reset mid-request; ack afterwards ignored.
    rst = 1'b1;
    step();
    rst = 1'b0; fetch_en = 1'b0;
    check("midrst_req",  {31'd0, icache_req}, 32'd0);
    check("midrst_addr", icache_addr,         32'h0);
    ack_once(32'h5555_5555, 1'b0);
    check("midrst_ack_valid", {31'd0, id_valid}, 32'd0);
    check("midrst_ack_busy",  {31'd0, busy},     32'd0);

    // Redirect while idle.
    redirect_req = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_req = 1'b0;
    check("idle_rd_busy", {31'd0, busy}, 32'd0);
    check("idle_rd_addr", icache_addr,   32'h300);
    fetch_en = 1'b1;
    wait_req("idle_rd", 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
